// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - sensor conditioning, hour counter and entry/exit barrier FSMs for ParkingSystem
module parking_gate_controller #(
    parameter int TICKS_PER_HOUR  = 400,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_sensor,
    input  logic       entry_badge,
    input  logic       exit_sensor,
    input  logic       exit_badge,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic [4:0] hour,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic       entry_barrier_open,
    output logic       exit_barrier_open,
    output logic       entry_denied
);

    localparam int TW = (TICKS_PER_HOUR > 2) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_HOUR - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        E_IDLE,
        E_DECIDE,
        E_OPEN,
        E_COUNT,
        E_DENY
    } entry_state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_CAPTURE,
        X_OPEN,
        X_COUNT
    } exit_state_t;

    // index 0 = entry loop, index 1 = exit loop
    logic [1:0]    w_raw;
    logic [1:0]    r_filt;
    logic [DW-1:0] r_db_cnt [2];
    logic [TW-1:0] r_tick;
    logic [4:0]    r_hour;
    logic          r_entry_uni;
    logic          r_exit_uni;
    logic          w_allowed;

    entry_state_t r_entry_state, w_entry_next;
    exit_state_t  r_exit_state,  w_exit_next;

    assign w_raw = {exit_sensor, entry_sensor};

    // Debounce: flip the filtered value only after DEBOUNCE_CYCLES disagreeing samples in a row
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                r_filt[s]   <= 1'b0;
                r_db_cnt[s] <= '0;
            end else if (w_raw[s] == r_filt[s]) begin
                r_db_cnt[s] <= '0;
            end else if (r_db_cnt[s] == DB_LAST) begin
                r_filt[s]   <= w_raw[s];
                r_db_cnt[s] <= '0;
            end else begin
                r_db_cnt[s] <= r_db_cnt[s] + 1'b1;
            end
        end
    end

    // Free-running time of day: hour advances once per TICKS_PER_HOUR cycles, wrapping 23 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= '0;
            r_hour <= '0;
        end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // State registers and the car-class latches captured in DECIDE / CAPTURE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry_state <= E_IDLE;
            r_exit_state  <= X_IDLE;
            r_entry_uni   <= 1'b0;
            r_exit_uni    <= 1'b0;
        end else begin
            r_entry_state <= w_entry_next;
            r_exit_state  <= w_exit_next;
            if (r_entry_state == E_DECIDE) begin
                r_entry_uni <= entry_badge;
            end
            if (r_exit_state == X_CAPTURE) begin
                r_exit_uni <= exit_badge;
            end
        end
    end

    // Capacity check uses the zone matching the badge presented at the moment of decision
    assign w_allowed = entry_badge ? uni_is_vacated_space : is_vacated_space;

    // Entry FSM next-state; space and badge inputs only matter in DECIDE
    always_comb begin
        w_entry_next = r_entry_state;
        case (r_entry_state)
            E_IDLE:   if (r_filt[0]) w_entry_next = E_DECIDE;
            E_DECIDE: w_entry_next = w_allowed ? E_OPEN : E_DENY;
            E_OPEN:   if (!r_filt[0]) w_entry_next = E_COUNT;
            E_COUNT:  w_entry_next = E_IDLE;
            E_DENY:   if (!r_filt[0]) w_entry_next = E_IDLE;
            default:  w_entry_next = E_IDLE;
        endcase
    end

    // Exit FSM next-state; departures never need a capacity check
    always_comb begin
        w_exit_next = r_exit_state;
        case (r_exit_state)
            X_IDLE:    if (r_filt[1]) w_exit_next = X_CAPTURE;
            X_CAPTURE: w_exit_next = X_OPEN;
            X_OPEN:    if (!r_filt[1]) w_exit_next = X_COUNT;
            X_COUNT:   w_exit_next = X_IDLE;
            default:   w_exit_next = X_IDLE;
        endcase
    end

    // Moore outputs decoded from the current states
    always_comb begin
        entry_barrier_open = (r_entry_state == E_OPEN);
        car_entered        = (r_entry_state == E_COUNT);
        entry_denied       = (r_entry_state == E_DENY);
        exit_barrier_open  = (r_exit_state == X_OPEN);
        car_exited         = (r_exit_state == X_COUNT);
    end

    assign hour               = r_hour;
    assign is_uni_car_entered = r_entry_uni;
    assign is_uni_car_exited  = r_exit_uni;

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Upstream front-end for ParkingSystem.
- Conditions the raw entry and exit loop-detector sensors and uni badge readers, and runs one barrier FSM per gate.
- Drives ParkingSystem's car_entered / is_uni_car_entered / car_exited / is_uni_car_exited event inputs, plus its hour input from an internal time-of-day counter.
- Consumes ParkingSystem's uni_is_vacated_space / is_vacated_space to refuse entry when the relevant zone is full.

Parameters:
- TICKS_PER_HOUR, 400, clk cycles per simulated hour (must be ≥2).
- DEBOUNCE_CYCLES, 3, consecutive identical samples required to change a filtered sensor (must be ≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- entry_sensor  input  1  raw entry loop detector, 1 = vehicle present.
- entry_badge  input  1  uni badge valid at entry reader.
- exit_sensor  input  1  raw exit loop detector.
- exit_badge  input  1  uni badge valid at exit reader.
- uni_is_vacated_space  input  1  from ParkingSystem, 1 = uni zone has room.
- is_vacated_space  input  1  from ParkingSystem, 1 = general zone has room.
- hour  output  5  time of day, 0..23.
- car_entered  output  1  one-cycle pulse per admitted car.
- is_uni_car_entered  output  1  class of last admitted/deciding car.
- car_exited  output  1  one-cycle pulse per departed car.
- is_uni_car_exited  output  1  class of last exiting car.
- entry_barrier_open  output  1  entry barrier command.
- exit_barrier_open  output  1  exit barrier command.
- entry_denied  output  1  "full" lamp.

Behaviour:
Reset:
- All outputs 0.
- Tick counter 0; both FSMs IDLE; filtered sensors 0; debounce counters 0.
- Reset mid-transaction aborts it: no pulse is emitted, and barriers close on the reset edge.

Debounce (per sensor):
- Filtered value flips after DEBOUNCE_CYCLES consecutive rising-edge samples that differ from it.
- Any agreeing sample clears the counter.
- A sensor already high when reset releases is treated as a new arrival.

Hour counter:
- Tick runs 0..TICKS_PER_HOUR-1.
- On the edge where tick == TICKS_PER_HOUR-1: tick returns to 0 and hour increments.
- hour 23 wraps to 0. Free-running, independent of the gates.

Entry FSM (Moore outputs):
- IDLE: filtered entry rises -> DECIDE.
- DECIDE (1 cycle):
  - Latch uni = entry_badge and drive it onto is_uni_car_entered; it holds until the next DECIDE.
  - Allowed = uni ? uni_is_vacated_space : is_vacated_space.
  - Allowed -> OPEN; otherwise -> DENY.
- OPEN: entry_barrier_open = 1; filtered entry falls -> COUNT.
- COUNT (1 cycle): car_entered = 1, barrier 0 -> IDLE.
- DENY: entry_denied = 1 until filtered entry falls -> IDLE. No pulse. A badge or space change while in DENY is ignored.

Exit FSM:
- IDLE -> CAPTURE on filtered exit rise. CAPTURE latches is_uni_car_exited = exit_badge for 1 cycle; no capacity check.
- CAPTURE -> OPEN (exit_barrier_open = 1) -> COUNT on fall (car_exited = 1 for one cycle) -> IDLE.

Timing:
- Barrier rises on the (DEBOUNCE_CYCLES+2)th consecutive edge sampling the sensor high.
- Count pulse is high after the (DEBOUNCE_CYCLES+1)th consecutive edge sampling it low. The barrier drops on that same edge.
- Space inputs are sampled only in DECIDE.
- Entry and exit FSMs are fully independent: simultaneous car_entered and car_exited pulses in the same cycle are legal and both are emitted.
- Sensor glitches shorter than DEBOUNCE_CYCLES produce no state change.

Test Plan (DEBOUNCE_CYCLES=3, TICKS_PER_HOUR=4):
- Reset then idle 96 cycles -> hour steps every 4 cycles, 0..23, back to 0 at cycle 96. All other outputs stay 0.
- entry_sensor high 10 cycles, badge=1, uni space=1:
  - entry_barrier_open rises on the 5th high edge.
  - After the sensor drops, car_entered pulses exactly one cycle on the 4th low edge.
  - is_uni_car_entered = 1.
- General car (badge=0) with is_vacated_space=0, sensor high 8 cycles -> entry_denied = 1 while present, barrier stays 0, no car_entered pulse. A following uni car with uni space=1 is admitted.
- 2-cycle entry_sensor glitch and 1-cycle exit glitch -> no barrier, no pulses, FSMs stay IDLE.
- Entry and exit cars release on the same cycle -> car_entered and car_exited pulse in the same cycle, with class flags matching the respective badges.
- Assert reset while entry FSM is in OPEN -> barrier 0 next edge, no car_entered, hour 0. A sensor held high after release re-triggers after debounce.
